// File: rtl/gpu_pkg.sv
// Shared constants and types for the pixel-plot sink: screen geometry,
// colour width, plot entry layout and the clear sequencer state encoding.
package gpu_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned PLOT_W   = X_W + Y_W + COLOUR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for queued plots; full/empty are registered so the
// sender-facing ready never depends combinationally on push or pop.
module pixel_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned WIDTH = PLOT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Next pointer, occupancy and flag computation.
  always_comb begin
    do_push = push && !full_q;
    do_pop  = pop && !empty_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == (AW+1)'(0));
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pixel_plot_sink.sv
// Receives rasteriser plots, range-checks and queues them, and writes them to
// the framebuffer; a clear sequencer can sweep the whole screen with one colour.
module pixel_plot_sink
  import gpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = gpu_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = gpu_pkg::SCREEN_H,
  parameter int unsigned ADDR_W     = gpu_pkg::ADDR_W
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                plot,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                ready,
  input  logic                clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int unsigned         NUM_PIX   = SCREEN_W * SCREEN_H;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [X_W-1:0]      X_LIMIT   = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0]      Y_LIMIT   = Y_W'(SCREEN_H);

  // y*320 + x without a multiplier.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] px,
                                                   input logic [Y_W-1:0] py);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(py);
    return (yw << 4'd8) + (yw << 4'd6) + ADDR_W'(px);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [COLOUR_W-1:0] clr_colour_q, clr_colour_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          drop_q, drop_d;

  plot_t fifo_din, fifo_dout;
  logic  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic  in_range, accept;

  assign in_range  = (x < X_LIMIT) && (y < Y_LIMIT);
  assign accept    = plot && !fifo_full;
  assign fifo_push = accept && in_range;
  assign fifo_din  = '{x: x, y: y, colour: colour};

  pixel_fifo #(
    .WIDTH (PLOT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer next state: clear sweep, FIFO drain and drop accounting.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_colour_d = clr_colour_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d      = ST_CLEAR;
          clr_cnt_d    = {ADDR_W{1'b0}};
          clr_colour_d = clear_colour;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = pixel_addr(fifo_dout.x, fifo_dout.y);
          mem_data_d = fifo_dout.colour;
        end else begin
          mem_we_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        // Further clear pulses are deliberately not looked at here.
        mem_we_d   = 1'b1;
        mem_addr_d = clr_cnt_q;
        mem_data_d = clr_colour_q;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = {ADDR_W{1'b0}};
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = {ADDR_W{1'b0}};
        mem_we_d  = 1'b0;
      end
    endcase

    if (accept && !in_range) begin
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // Sequencer state and registered framebuffer outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= {ADDR_W{1'b0}};
      clr_colour_q <= {COLOUR_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_data_q   <= {COLOUR_W{1'b0}};
      mem_we_q     <= 1'b0;
      drop_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_colour_q <= clr_colour_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      drop_q       <= drop_d;
    end
  end

  assign ready      = !fifo_full;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign drop_count = drop_q;
  assign busy       = (state_q == ST_CLEAR) || !fifo_empty || mem_we_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Self-checking bench for pixel_plot_sink: random plots against a queue-based
// reference model, plus clear, back-pressure and reset scenarios.
module tb_pixel_plot_sink;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        plot = 1'b0;
  logic [8:0]  x = 9'd0;
  logic [7:0]  y = 8'd0;
  logic [2:0]  colour = 3'd0;
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = 3'd0;
  logic        ready, mem_we, busy;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int drop_model = 0;

  typedef struct { logic [16:0] addr; logic [2:0] data; int cyc; } wr_t;
  wr_t wr_q[$];

  pixel_plot_sink dut (
    .clock(clock), .rst(rst), .plot(plot), .x(x), .y(y), .colour(colour),
    .ready(ready), .clear(clear), .clear_colour(clear_colour),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (mem_we === 1'b1) wr_q.push_back('{mem_addr, mem_data, cyc});

  function automatic logic [16:0] exp_addr(input int px, input int py);
    return 17'(py * 320 + px);
  endfunction

  // Present a plot and hold it until ready; returns after the accepting edge.
  task automatic drive_plot(input int px, input int py, input int pc,
                            output int acc_cyc, output int waited);
    waited = 0;
    plot = 1'b1; x = 9'(px); y = 8'(py); colour = 3'(pc);
    while (ready !== 1'b1 && waited < 90000) begin
      @(negedge clock);
      waited++;
    end
    @(negedge clock);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int g = 0;
    while (busy !== 1'b0 && g < limit) begin
      @(negedge clock);
      g++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; plot = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 17'd0) begin errors++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_data !== 3'd0) begin errors++; $display("FAIL reset_mem_data got=%0d exp=0", mem_data); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    drop_model = 0;
    wr_q.delete();
  endtask

  task automatic test_single;
    int acc, w; bit ok;
    wr_q.delete();
    drive_plot(5, 2, 5, acc, w);
    plot = 1'b0;
    repeat (5) @(negedge clock);
    wait_idle(20, ok);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].addr !== exp_addr(5, 2)) begin errors++; $display("FAIL single_addr got=%0d exp=%0d", wr_q[0].addr, exp_addr(5, 2)); end
      checks++; if (wr_q[0].data !== 3'd5) begin errors++; $display("FAIL single_data got=%0d exp=5", wr_q[0].data); end
      checks++; if (wr_q[0].cyc != acc + 1) begin errors++; $display("FAIL single_latency got=%0d exp=1", wr_q[0].cyc - acc); end
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_corner;
    int acc, w;
    wr_q.delete();
    drive_plot(319, 239, 3, acc, w);
    plot = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL corner_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].addr !== exp_addr(319, 239)) begin errors++; $display("FAIL corner_addr got=%0d exp=%0d", wr_q[0].addr, exp_addr(319, 239)); end
    end
    drive_plot(320, 0, 1, acc, w);
    drop_model++;
    plot = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL oob_no_write got=%0d exp=1", wr_q.size()); end
    checks++; if (drop_count !== 8'(drop_model)) begin errors++; $display("FAIL oob_drop got=%0d exp=%0d", drop_count, drop_model); end
  endtask

  task automatic test_random;
    int acc, w, stalls, px, py, pc, n; bit ok;
    logic [19:0] exp_q[$];
    wr_q.delete(); stalls = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        pc = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            px = $urandom_range(320, 511); py = $urandom_range(0, 255);
          end else begin
            px = $urandom_range(0, 319); py = $urandom_range(240, 255);
          end
          if (drop_model < 255) drop_model++;
        end else begin
          px = $urandom_range(0, 319); py = $urandom_range(0, 239);
          exp_q.push_back({exp_addr(px, py), 3'(pc)});
        end
        drive_plot(px, py, pc, acc, w);
        stalls += w;
      end else begin
        plot = 1'b0;
        @(negedge clock);
      end
    end
    plot = 1'b0;
    wait_idle(50, ok);
    checks++; if (stalls != 0) begin errors++; $display("FAIL random_stalls got=%0d exp=0", stalls); end
    checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({wr_q[i].addr, wr_q[i].data} !== exp_q[i]) begin
        errors++;
        $display("FAIL random_write[%0d] got=%0d/%0d exp=%0d/%0d", i, wr_q[i].addr, wr_q[i].data, exp_q[i][19:3], exp_q[i][2:0]);
      end
    end
    checks++; if (drop_count !== 8'(drop_model)) begin errors++; $display("FAIL random_drop got=%0d exp=%0d", drop_count, drop_model); end
  endtask

  task automatic test_saturate;
    int acc, w;
    wr_q.delete();
    for (int i = 0; i < 300; i++) begin
      drive_plot($urandom_range(320, 511), $urandom_range(0, 255), $urandom_range(0, 7), acc, w);
      if (drop_model < 255) drop_model++;
    end
    plot = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (drop_count !== 8'(drop_model)) begin errors++; $display("FAIL sat_drop_model got=%0d exp=%0d", drop_count, drop_model); end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop_255 got=%0d exp=255", drop_count); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL sat_no_write got=%0d exp=0", wr_q.size()); end
  endtask

  task automatic test_back_to_back;
    int acc[64]; int w, stalls, x0, y0, dy, px, py; bit ok;
    logic [19:0] exp_q[$];
    wr_q.delete(); stalls = 0;
    x0 = $urandom_range(0, 250); y0 = $urandom_range(0, 150); dy = $urandom_range(0, 80);
    for (int i = 0; i < 64; i++) begin
      px = x0 + i; py = y0 + (i * dy) / 64;
      exp_q.push_back({exp_addr(px, py), 3'(i % 8)});
      drive_plot(px, py, i % 8, acc[i], w);
      stalls += w;
    end
    plot = 1'b0;
    wait_idle(50, ok);
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=0", stalls); end
    checks++; if (wr_q.size() != 64) begin errors++; $display("FAIL b2b_count got=%0d exp=64", wr_q.size()); end
    if (wr_q.size() == 64) begin
      checks++; if (wr_q[0].cyc != acc[0] + 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=1", wr_q[0].cyc - acc[0]); end
      for (int i = 0; i < 64; i++) begin
        checks++;
        if ({wr_q[i].addr, wr_q[i].data} !== exp_q[i] || wr_q[i].cyc != wr_q[0].cyc + i) begin
          errors++;
          $display("FAIL b2b_write[%0d] got=%0d/%0d@%0d exp=%0d/%0d@%0d", i, wr_q[i].addr, wr_q[i].data,
                   wr_q[i].cyc, exp_q[i][19:3], exp_q[i][2:0], wr_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_clear_queue;
    int acc[6]; int w[6]; int px[6]; int py[6]; int pc[6];
    int bad, first_bad; bit ok;
    for (int i = 0; i < 6; i++) begin
      px[i] = $urandom_range(0, 319); py[i] = $urandom_range(0, 239); pc[i] = $urandom_range(0, 7);
    end
    wr_q.delete();
    clear = 1'b1; clear_colour = 3'b010;
    @(negedge clock);
    clear = 1'b0; clear_colour = 3'b110;
    for (int i = 0; i < 4; i++) drive_plot(px[i], py[i], pc[i], acc[i], w[i]);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready_full got=%b exp=0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got=%b exp=1", busy); end
    plot = 1'b0;
    repeat (30000) @(negedge clock);
    clear = 1'b1; clear_colour = 3'b111;
    @(negedge clock);
    clear = 1'b0;
    for (int i = 4; i < 6; i++) drive_plot(px[i], py[i], pc[i], acc[i], w[i]);
    plot = 1'b0;
    checks++; if (w[4] == 0 || w[4] >= 90000) begin errors++; $display("FAIL clear_plot5_held got=%0d exp=1..89999", w[4]); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clear_idle got=%b exp=0", busy); end
    checks++; if (wr_q.size() != 76806) begin errors++; $display("FAIL clear_count got=%0d exp=76806", wr_q.size()); end
    if (wr_q.size() == 76806) begin
      bad = 0; first_bad = -1;
      for (int i = 0; i < 76800; i++) begin
        if (wr_q[i].addr !== 17'(i) || wr_q[i].data !== 3'b010 || wr_q[i].cyc != wr_q[0].cyc + i) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL clear_seq bad=%0d exp=0 first_at=%0d", bad, first_bad); end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_q[76800 + i].addr !== exp_addr(px[i], py[i]) || wr_q[76800 + i].data !== 3'(pc[i])) begin
          errors++;
          $display("FAIL clear_queued[%0d] got=%0d/%0d exp=%0d/%0d", i, wr_q[76800 + i].addr,
                   wr_q[76800 + i].data, exp_addr(px[i], py[i]), pc[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid_clear;
    int acc, w, g; bit found;
    wr_q.delete();
    clear = 1'b1; clear_colour = 3'b001;
    @(negedge clock);
    clear = 1'b0;
    drive_plot(10, 10, 4, acc, w);
    drive_plot(20, 20, 6, acc, w);
    plot = 1'b0;
    g = 0; found = 1'b0;
    while (!found && g < 2000) begin
      if (mem_we === 1'b1 && mem_addr === 17'd1000) found = 1'b1;
      else begin @(negedge clock); g++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_1000 got=%0d exp=1000", mem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got=%b exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clock);
    rst = 1'b0;
    wr_q.delete();
    repeat (20) @(negedge clock);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL rst_no_writes got=%0d exp=0", wr_q.size()); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_random();
    test_saturate();
    test_back_to_back();
    test_clear_queue();
    test_rst_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_plot_sink.md
Name: pixel_plot_sink

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the line rasteriser.
- Accepts plot strobes into a small FIFO and range-checks the coordinates.
- Converts each accepted (x, y) to a linear 320x240 framebuffer address and issues single-cycle writes to the framebuffer RAM write port.
- Also provides a full-screen clear sequencer, so the shape drawer can erase the previous frame before it redraws.

Parameters:
- FIFO_DEPTH, 4: plot FIFO entries; must be a power of 2, minimum 2.
- SCREEN_W, 320: horizontal pixels.
- SCREEN_H, 240: vertical pixels.
- ADDR_W, 17: framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H (76800).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- plot  in  1  pixel write request, qualified by ready.
- x  in  9  pixel column.
- y  in  8  pixel row.
- colour  in  3  RGB, 1 bit per channel.
- ready  out  1  high when the FIFO can accept a plot (FIFO not full).
- clear  in  1  single-cycle pulse that starts a screen clear.
- clear_colour  in  3  fill colour; sampled on the cycle clear is accepted.
- mem_addr  out  ADDR_W  framebuffer write address.
- mem_data  out  3  framebuffer write data.
- mem_we  out  1  framebuffer write enable, one cycle per pixel.
- busy  out  1  high while clearing, while the FIFO is non-empty, or while mem_we is high.
- drop_count  out  8  saturating count of out-of-range plots.

Behaviour:
- Reset (asynchronous, any state including mid-clear):
  - state = IDLE, FIFO emptied.
  - mem_we=0, mem_addr=0, mem_data=0, drop_count=0, busy=0.
  - ready=1 once rst deasserts.
- Accept: a plot is taken on a rising edge where plot=1 and ready=1. A plot with ready=0 is ignored; the sender must hold it.
- Range check at accept:
  - x>=SCREEN_W or y>=SCREEN_H: not enqueued; drop_count increments, saturating at 255.
  - Otherwise {x, y, colour} is enqueued.
- Address: addr = y*320 + x, computed as (y<<8) + (y<<6) + x in ADDR_W bits. Max in-range value is 76799; no wrap.
- States: IDLE, CLEAR.
- IDLE:
  - clear=1 -> CLEAR. clear_colour is latched and the clear counter is set to 0. No FIFO pop that cycle.
  - Else, if the FIFO is non-empty, pop the head and register mem_addr, mem_data and mem_we=1.
  - Else mem_we=0.
- CLEAR:
  - Each cycle: mem_addr = counter, mem_data = latched colour, mem_we=1; counter increments.
  - After the write of address 76799 -> IDLE. Total 76800 write cycles.
  - clear pulses during CLEAR are ignored.
  - The FIFO is not popped but keeps accepting until full. Queued plots drain after the clear, so they land on top of the cleared screen.
- Latency, FIFO empty: a plot accepted at edge k puts mem_we/mem_addr/mem_data valid from edge k+1 to edge k+2.
- Throughput: 1 pixel per cycle sustained.
- Simultaneous push and pop in the same cycle is legal. ready is derived from registered fullness (not full), so it never depends combinationally on plot.
- Simultaneous clear and plot: both are honoured; the plot is enqueued.
- mem_addr and mem_data hold their last values when mem_we=0.

Decomposition:
- Shared package gpu_pkg:
  - SCREEN_W, SCREEN_H, ADDR_W.
  - colour width constant COLOUR_W=3.
  - state encoding for IDLE/CLEAR.
- Sub-module pixel_fifo: synchronous FIFO, width 20 (x9, y8, colour3), depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Asynchronous active-high reset.
- Address arithmetic and the clear sequencer stay in the top module.

Test Plan:
- Reset, then plot x=5 y=2 colour=3'b101 for one cycle -> exactly one mem_we pulse with mem_addr=645 and mem_data=5, one cycle after the accept edge; busy then returns to 0.
- Plot x=319 y=239 -> mem_addr=76799. Plot x=320 y=0 -> no write and drop_count=1. Send 300 out-of-range plots -> drop_count holds 255.
- Hold mem writes off with clear active, then issue 6 consecutive plots -> ready drops after 4 are accepted; plots 5 and 6 are held by the sender; all 6 are written in order after the clear completes.
- Pulse clear with clear_colour=3'b010 -> 76800 consecutive mem_we cycles, addresses 0..76799, data 2. A second clear pulse mid-way does not restart the count.
- Assert rst mid-clear at address 1000 with 2 entries queued -> mem_we=0 immediately, and no writes occur after rst deasserts.
- Drive plot every cycle with in-range coordinates (a line pattern) -> ready stays 1 and each point produces exactly one write, in the same order, at 1 pixel per cycle.
